// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath widths, decoder control bundle, opcodes.
// Ports: none (package).
// The ex_reg_t record is the full ID/EX pipeline word.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // Writeback source select
  localparam logic [1:0] MEM_TO_REG_ALU = 2'd0;
  localparam logic [1:0] MEM_TO_REG_MEM = 2'd1;
  localparam logic [1:0] MEM_TO_REG_PC4 = 2'd2;

  // ALU operand A source select
  localparam logic [1:0] ASRC_PC   = 2'd0;
  localparam logic [1:0] ASRC_ZERO = 2'd1;
  localparam logic [1:0] ASRC_RS1  = 2'd2;

  // Decoder opcodes (RV32I)
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic [1:0] mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] auipclui;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '0;

  typedef struct packed {
    logic                  valid;
    ctrl_bundle_t          ctrl;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [2:0]            funct3;
    logic                  funct7_5;
  } ex_reg_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: ID-side instruction fields, flush/hold, EX-side copies, stall.
// Ports: master drives id_* / flush / hold and observes ex_* / stall;
//        slave (the pipeline register) is the reverse.
interface id_ex_stage_if;
  import cpu_pkg::*;

  logic                  id_valid;
  logic [XLEN-1:0]       id_pc;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [XLEN-1:0]       id_imm;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [2:0]            id_funct3;
  logic                  id_funct7_5;
  ctrl_bundle_t          id_ctrl;
  logic                  flush;
  logic                  hold;

  logic                  ex_valid;
  logic [XLEN-1:0]       ex_pc;
  logic [XLEN-1:0]       ex_rs1_data;
  logic [XLEN-1:0]       ex_rs2_data;
  logic [XLEN-1:0]       ex_imm;
  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [2:0]            ex_funct3;
  logic                  ex_funct7_5;
  ctrl_bundle_t          ex_ctrl;
  logic                  stall;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_funct3, id_funct7_5, id_ctrl, flush, hold,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_funct3, ex_funct7_5, ex_ctrl, stall
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_funct3, id_funct7_5, id_ctrl, flush, hold,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_funct3, ex_funct7_5, ex_ctrl, stall
  );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: EX holds a register-writing load whose rd feeds the ID instruction.
// Ports: EX-side valid/mem_to_reg/reg_write/rd, ID-side rs1/rs2/valid in; lu_o out.
// Purely combinational.
module load_use_detect (
  input  logic       ex_valid_i,
  input  logic [1:0] ex_mem_to_reg_i,
  input  logic       ex_reg_write_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_valid_i,
  output logic       lu_o
);
  import cpu_pkg::*;

  // Keyed on mem_to_reg rather than mem_read: stores, AUIPC and LUI also
  // raise mem_read but never return load data to the register file.
  assign lu_o = ex_valid_i
              & (ex_mem_to_reg_i == MEM_TO_REG_MEM)
              & ex_reg_write_i
              & (ex_rd_i != 5'd0)
              & ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i))
              & id_valid_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Ports: clk_i, rst_i (sync, active-high); pipe (slave) carries ID inputs,
//        flush/hold, registered EX outputs and the combinational stall.
module id_ex_stage (
  input logic          clk_i,
  input logic          rst_i,
  id_ex_stage_if.slave pipe
);
  import cpu_pkg::*;

  ex_reg_t ex_q;
  ex_reg_t load_d;
  logic    lu;

  load_use_detect u_lud (
    .ex_valid_i      (ex_q.valid),
    .ex_mem_to_reg_i (ex_q.ctrl.mem_to_reg),
    .ex_reg_write_i  (ex_q.ctrl.reg_write),
    .ex_rd_i         (ex_q.rd),
    .id_rs1_i        (pipe.id_rs1),
    .id_rs2_i        (pipe.id_rs2),
    .id_valid_i      (pipe.id_valid),
    .lu_o            (lu)
  );

  // Word that would be captured on a normal load. Controls of an empty ID
  // slot are forced off so they cannot cause side effects downstream.
  always_comb begin
    load_d          = '0;
    load_d.valid    = pipe.id_valid;
    load_d.ctrl     = pipe.id_valid ? pipe.id_ctrl : CTRL_NOP;
    load_d.pc       = pipe.id_pc;
    load_d.rs1_data = pipe.id_rs1_data;
    load_d.rs2_data = pipe.id_rs2_data;
    load_d.imm      = pipe.id_imm;
    load_d.rs1      = pipe.id_rs1;
    load_d.rs2      = pipe.id_rs2;
    load_d.rd       = pipe.id_rd;
    load_d.funct3   = pipe.id_funct3;
    load_d.funct7_5 = pipe.id_funct7_5;
  end

  // Priority: reset > flush > hold > load-use > load.
  // Bubbles only kill valid and controls; data fields are don't-care.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q <= '0;
    end else if (pipe.flush) begin
      ex_q       <= load_d;
      ex_q.valid <= 1'b0;
      ex_q.ctrl  <= CTRL_NOP;
    end else if (pipe.hold) begin
      ex_q <= ex_q;
    end else if (lu) begin
      ex_q       <= load_d;
      ex_q.valid <= 1'b0;
      ex_q.ctrl  <= CTRL_NOP;
    end else begin
      ex_q <= load_d;
    end
  end

  // A flush kills the stalled ID instruction, so it must not freeze upstream.
  assign pipe.stall = (lu | pipe.hold) & ~pipe.flush & ~rst_i;

  assign pipe.ex_valid    = ex_q.valid;
  assign pipe.ex_ctrl     = ex_q.ctrl;
  assign pipe.ex_pc       = ex_q.pc;
  assign pipe.ex_rs1_data = ex_q.rs1_data;
  assign pipe.ex_rs2_data = ex_q.rs2_data;
  assign pipe.ex_imm      = ex_q.imm;
  assign pipe.ex_rs1      = ex_q.rs1;
  assign pipe.ex_rs2      = ex_q.rs2;
  assign pipe.ex_rd       = ex_q.rd;
  assign pipe.ex_funct3   = ex_q.funct3;
  assign pipe.ex_funct7_5 = ex_q.funct7_5;

endmodule
